// File: rtl/ca_engine_if.sv
// Control and status bundle between a cellular-automaton engine and whatever drives it.
// The engine takes the slave side; the controller or testbench takes the master side.
interface ca_engine_if #(
    parameter int WIDTH = 16,
    parameter int DIV_W = 8,
    parameter int GEN_W = 16
);
    logic             load;
    logic [WIDTH-1:0] seed;
    logic [7:0]       rule;
    logic             boundary;
    logic             run;
    logic             step;
    logic [DIV_W-1:0] period;

    logic [WIDTH-1:0] cur;
    logic [GEN_W-1:0] gen;
    logic             adv;
    logic             stable;
    logic             halted;

    modport master (
        output load, seed, rule, boundary, run, step, period,
        input  cur, gen, adv, stable, halted
    );

    modport slave (
        input  load, seed, rule, boundary, run, step, period,
        output cur, gen, adv, stable, halted
    );
endinterface

// File: rtl/ca_engine.sv
// Radius-1 elementary cellular automaton engine with single-step and free-run modes.
// Free-run stops automatically when a generation reproduces itself.
module ca_engine #(
    parameter int WIDTH = 16,
    parameter int DIV_W = 8,
    parameter int GEN_W = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    ca_engine_if.slave  bus
);

    typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;

    state_t           state;
    state_t           state_next;
    logic [DIV_W-1:0] tick;
    logic [DIV_W-1:0] tick_next;
    logic             do_adv;

    logic [WIDTH-1:0] cur_q;
    logic [WIDTH-1:0] nxt;
    logic [WIDTH-1:0] left_n;
    logic [WIDTH-1:0] right_n;
    logic [GEN_W-1:0] gen_q;
    logic             adv_q;
    logic             stable_q;

    // Bit i of left_n/right_n is the left (i+1) / right (i-1) neighbour of cell i.
    assign left_n  = {(bus.boundary ? 1'b0 : cur_q[0]), cur_q[WIDTH-1:1]};
    assign right_n = {cur_q[WIDTH-2:0], (bus.boundary ? 1'b0 : cur_q[WIDTH-1])};

    always_comb begin
        nxt = '0;
        for (int i = 0; i < WIDTH; i++) begin
            nxt[i] = bus.rule[{left_n[i], cur_q[i], right_n[i]}];
        end
    end

    always_comb begin
        state_next = state;
        tick_next  = tick;
        do_adv     = 1'b0;
        if (bus.load) begin
            state_next = IDLE;
            tick_next  = '0;
        end else begin
            case (state)
                IDLE: begin
                    tick_next = '0;
                    do_adv    = bus.step;
                    if (bus.run) begin
                        state_next = RUN;
                    end
                end
                RUN: begin
                    if (!bus.run) begin
                        state_next = IDLE;
                        tick_next  = '0;
                    end else if (tick == bus.period) begin
                        do_adv    = 1'b1;
                        tick_next = '0;
                        if (nxt == cur_q) begin
                            state_next = HALT;
                        end
                    end else begin
                        tick_next = tick + 1'b1;
                    end
                end
                HALT: begin
                    tick_next = '0;
                    if (!bus.run) begin
                        state_next = IDLE;
                    end
                end
                default: begin
                    state_next = IDLE;
                    tick_next  = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            tick  <= '0;
        end else begin
            state <= state_next;
            tick  <= tick_next;
        end
    end

    // gen saturates so a long free-run never wraps back to a small count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_q    <= '0;
            gen_q    <= '0;
            adv_q    <= 1'b0;
            stable_q <= 1'b0;
        end else if (bus.load) begin
            cur_q    <= bus.seed;
            gen_q    <= '0;
            adv_q    <= 1'b0;
            stable_q <= 1'b0;
        end else begin
            adv_q <= do_adv;
            if (do_adv) begin
                cur_q    <= nxt;
                gen_q    <= (gen_q == '1) ? gen_q : gen_q + 1'b1;
                stable_q <= (nxt == cur_q);
            end
        end
    end

    assign bus.cur    = cur_q;
    assign bus.gen    = gen_q;
    assign bus.adv    = adv_q;
    assign bus.stable = stable_q;
    assign bus.halted = (state == HALT);

endmodule

// File: tb/tb_ca_engine.sv
// Randomised and directed bench for ca_engine, checked every cycle against a behavioural model.
// A second instance with a 4-bit generation counter shares the stimulus to exercise saturation.
module tb_ca_engine;

    localparam int W        = 16;
    localparam int DW       = 8;
    localparam int TICK_MOD = 1 << DW;
    localparam logic [1:0] MODE_IDLE = 2'd0;
    localparam logic [1:0] MODE_RUN  = 2'd1;
    localparam logic [1:0] MODE_HALT = 2'd2;

    logic clk = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_fails  = 0;

    always #5 clk = ~clk;

    ca_engine_if #(.WIDTH(W), .DIV_W(DW), .GEN_W(16)) bus ();
    ca_engine_if #(.WIDTH(W), .DIV_W(DW), .GEN_W(4))  bus4 ();

    assign bus4.load     = bus.load;
    assign bus4.seed     = bus.seed;
    assign bus4.rule     = bus.rule;
    assign bus4.boundary = bus.boundary;
    assign bus4.run      = bus.run;
    assign bus4.step     = bus.step;
    assign bus4.period   = bus.period;

    ca_engine #(.WIDTH(W), .DIV_W(DW), .GEN_W(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    ca_engine #(.WIDTH(W), .DIV_W(DW), .GEN_W(4)) dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus4)
    );

    typedef struct packed {
        logic [W-1:0] cur;
        logic [31:0]  gen;
        logic [31:0]  tick;
        logic [1:0]   mode;
        logic         adv;
        logic         stable;
    } model_t;

    model_t m;

    // Neighbourhood lookup written straight from the index arithmetic of the rule.
    function automatic logic [W-1:0] next_gen(input logic [W-1:0] c, input logic [7:0] r, input logic b);
        logic [W-1:0] n;
        n = '0;
        for (int i = 0; i < W; i++) begin
            int li = i + 1;
            int ri = i - 1;
            int lv = (b && li >= W) ? 0 : int'(c[li % W]);
            int rv = (b && ri < 0)  ? 0 : int'(c[(ri + W) % W]);
            int cv = int'(c[i]);
            n[i] = r[lv * 4 + cv * 2 + rv];
        end
        return n;
    endfunction

    function automatic model_t model_step(input model_t s, input logic ld, input logic [W-1:0] sd,
                                          input logic [7:0] rl, input logic bd, input logic rn,
                                          input logic st, input logic [DW-1:0] pd);
        model_t t = s;
        logic [W-1:0] n = next_gen(s.cur, rl, bd);
        bit fire = 0;
        if (ld) begin
            t.cur = sd; t.gen = 0; t.tick = 0; t.mode = MODE_IDLE; t.stable = 0; t.adv = 0;
            return t;
        end
        if (s.mode == MODE_IDLE) begin
            fire = st;
            if (rn) begin
                t.mode = MODE_RUN;
                t.tick = 0;
            end
        end else if (s.mode == MODE_RUN) begin
            if (!rn) begin
                t.mode = MODE_IDLE;
                t.tick = 0;
            end else if (s.tick == 32'(pd)) begin
                fire = 1;
                t.tick = 0;
                if (n == s.cur) t.mode = MODE_HALT;
            end else begin
                t.tick = (s.tick + 1) % TICK_MOD;
            end
        end else if (!rn) begin
            t.mode = MODE_IDLE;
        end
        if (fire) begin
            t.stable = (n == s.cur);
            t.cur    = n;
            if (s.gen < 65535) t.gen = s.gen + 1;
        end
        t.adv = fire;
        return t;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m <= '0;
        else m <= model_step(m, bus.load, bus.seed, bus.rule, bus.boundary, bus.run, bus.step, bus.period);
    end

    task automatic checkValue(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic checkOutput();
        checkValue("cur",     32'(bus.cur),    32'(m.cur));
        checkValue("gen",     32'(bus.gen),    m.gen);
        checkValue("adv",     32'(bus.adv),    32'(m.adv));
        checkValue("stable",  32'(bus.stable), 32'(m.stable));
        checkValue("halted",  32'(bus.halted), 32'(m.mode == MODE_HALT));
        checkValue("cur4",    32'(bus4.cur),   32'(m.cur));
        checkValue("gen4",    32'(bus4.gen),   (m.gen > 15) ? 32'd15 : m.gen);
        checkValue("adv4",    32'(bus4.adv),   32'(m.adv));
    endtask

    task automatic applyStimulus(input logic ld, input logic st, input logic rn);
        @(negedge clk);
        if (rst_n) checkOutput();
        bus.load = ld;
        bus.step = st;
        bus.run  = rn;
    endtask

    initial begin
        int last;
        int cnt;
        int g;
        rst_n        = 1'b0;
        bus.load     = 1'b0;
        bus.step     = 1'b0;
        bus.run      = 1'b0;
        bus.seed     = '0;
        bus.rule     = '0;
        bus.boundary = 1'b0;
        bus.period   = '0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;

        applyStimulus(0, 0, 0);
        checkValue("reset_cur",    32'(bus.cur),    0);
        checkValue("reset_gen",    32'(bus.gen),    0);
        checkValue("reset_adv",    32'(bus.adv),    0);
        checkValue("reset_stable", 32'(bus.stable), 0);
        checkValue("reset_halted", 32'(bus.halted), 0);

        // Rule 30 single step from one live cell, wrap then zero edges.
        bus.rule = 8'd30; bus.seed = 16'h0001; bus.boundary = 1'b0;
        applyStimulus(1, 0, 0);
        applyStimulus(0, 1, 0);
        applyStimulus(0, 0, 0);
        checkValue("wrap_cur", 32'(bus.cur), 32'h8003);
        checkValue("wrap_gen", 32'(bus.gen), 1);
        checkValue("wrap_adv", 32'(bus.adv), 1);
        applyStimulus(0, 0, 0);
        checkValue("wrap_adv_drop", 32'(bus.adv), 0);

        bus.boundary = 1'b1;
        applyStimulus(1, 0, 0);
        applyStimulus(0, 1, 0);
        applyStimulus(0, 0, 0);
        checkValue("zero_cur", 32'(bus.cur), 32'h0003);

        // Free-run at period 3: advances every 4 cycles, then stop freezes gen.
        bus.boundary = 1'b0; bus.period = 8'd3;
        applyStimulus(1, 0, 0);
        applyStimulus(0, 0, 1);
        last = -1;
        cnt  = 0;
        for (int c = 1; c <= 25; c++) begin
            applyStimulus(0, 0, 1);
            if (bus.adv) begin
                if (last >= 0) checkValue("adv_gap", 32'(c - last), 4);
                last = c;
                cnt++;
            end
        end
        checkValue("adv_count", 32'(cnt), 6);
        applyStimulus(0, 0, 0);
        applyStimulus(0, 0, 0);
        g = int'(bus.gen);
        checkValue("run_gen", 32'(g), 6);
        cnt = 0;
        for (int c = 0; c < 10; c++) begin
            applyStimulus(0, 0, 0);
            if (bus.adv) cnt++;
        end
        checkValue("adv_after_stop", 32'(cnt), 0);
        checkValue("gen_frozen", 32'(bus.gen), 32'(g));

        // Rule 0 collapses to all-zero, then the repeat halts free-run.
        bus.rule = 8'd0; bus.seed = 16'hFFFF; bus.period = 8'd0;
        applyStimulus(1, 0, 0);
        applyStimulus(0, 0, 1);
        applyStimulus(0, 0, 1);
        applyStimulus(0, 0, 1);
        checkValue("r0_cur1",    32'(bus.cur),    0);
        checkValue("r0_stable1", 32'(bus.stable), 0);
        checkValue("r0_gen1",    32'(bus.gen),    1);
        applyStimulus(0, 0, 1);
        checkValue("r0_stable2", 32'(bus.stable), 1);
        checkValue("r0_halted",  32'(bus.halted), 1);
        checkValue("r0_gen2",    32'(bus.gen),    2);
        applyStimulus(0, 0, 1);
        checkValue("r0_no_adv",  32'(bus.adv),    0);
        checkValue("r0_gen_hold", 32'(bus.gen),   2);
        applyStimulus(0, 0, 0);
        applyStimulus(0, 0, 0);
        checkValue("r0_unhalt",  32'(bus.halted), 0);
        checkValue("r0_keep_stable", 32'(bus.stable), 1);

        // Load during free-run, then an asynchronous reset mid-cycle.
        bus.rule = 8'd30; bus.seed = 16'h0001; bus.period = 8'd1;
        applyStimulus(1, 0, 0);
        applyStimulus(0, 0, 1);
        repeat (5) applyStimulus(0, 0, 1);
        bus.seed = 16'h00F0;
        applyStimulus(1, 0, 1);
        applyStimulus(0, 0, 1);
        checkValue("mid_load_cur",    32'(bus.cur),    32'h00F0);
        checkValue("mid_load_gen",    32'(bus.gen),    0);
        checkValue("mid_load_halted", 32'(bus.halted), 0);
        repeat (4) applyStimulus(0, 0, 1);
        #2 rst_n = 1'b0;
        #1;
        checkValue("async_rst_cur", 32'(bus.cur), 0);
        checkValue("async_rst_gen", 32'(bus.gen), 0);
        bus.run = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b1;

        // Twenty steps overflow the 4-bit counter of the second instance.
        bus.rule = 8'd30; bus.seed = 16'h0001; bus.boundary = 1'b0;
        applyStimulus(1, 0, 0);
        repeat (20) applyStimulus(0, 1, 0);
        applyStimulus(0, 0, 0);
        checkValue("sat_gen16", 32'(bus.gen),  20);
        checkValue("sat_gen4",  32'(bus4.gen), 32'hF);

        // Random traffic including mid-run rule, edge and period changes.
        begin
            logic rn;
            rn = 1'b0;
            for (int k = 0; k < 3000; k++) begin
                logic ld;
                logic st;
                int   p;
                ld = ($urandom_range(0, 99) < 2);
                st = ($urandom_range(0, 99) < 25);
                if ($urandom_range(0, 99) < 4) rn = ~rn;
                if (ld) bus.seed = W'($urandom);
                if ($urandom_range(0, 99) < 5) bus.rule = 8'($urandom_range(0, 255));
                if ($urandom_range(0, 99) < 5) bus.boundary = ~bus.boundary;
                p = $urandom_range(0, 99);
                if (p < 3) bus.period = 8'($urandom_range(0, 5));
                else if (p == 3) bus.period = 8'($urandom_range(200, 255));
                applyStimulus(ld, st, rn);
            end
        end
        applyStimulus(0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
